// File: rtl/ascii_pkg.sv
// Shared types, default geometry and address helper for the ASCII tile sequencer.
// The optional fill watchdog is enabled with ASCII_SEQ_TIMEOUT_EN.
package ascii_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, FILL, WAIT, WRITE, DONE} seq_state_t;

  localparam int DEF_FRAME_W      = 640;
  localparam int DEF_FRAME_H      = 480;
  localparam int DEF_TILE_W       = 8;
  localparam int DEF_TILE_H       = 8;
  localparam int DEF_ASCII_LEVELS = 8;
  localparam int DEF_TIMEOUT      = 64;

  function automatic int tile_addr(input int x, input int y, input int cols);
    return y * cols + x;
  endfunction

endpackage

// File: rtl/ascii_tile_cursor.sv
// Raster-order tile column/row counters; last flags the bottom-right tile.
module ascii_tile_cursor #(
  parameter int COLS = 80,
  parameter int ROWS = 60,
  parameter int XW   = 7,
  parameter int YW   = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [XW-1:0] tile_x,
  output logic [YW-1:0] tile_y,
  output logic          last
);

  logic x_end;
  logic y_end;

  assign x_end = (tile_x == XW'(COLS - 1));
  assign y_end = (tile_y == YW'(ROWS - 1));
  assign last  = x_end && y_end;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      tile_x <= '0;
      tile_y <= '0;
    end else if (advance) begin
      if (x_end) begin
        tile_x <= '0;
        tile_y <= y_end ? '0 : tile_y + YW'(1);
      end else begin
        tile_x <= tile_x + XW'(1);
      end
    end
  end

endmodule

// File: rtl/ascii_tile_sequencer.sv
// Frame controller: per tile LOAD -> FILL -> WAIT -> WRITE, then a DONE pulse.
// Define ASCII_SEQ_TIMEOUT_EN to add the WAIT watchdog and sticky timeout_err.
module ascii_tile_sequencer
  import ascii_pkg::*;
#(
  parameter int FRAME_W      = DEF_FRAME_W,
  parameter int FRAME_H      = DEF_FRAME_H,
  parameter int TILE_W       = DEF_TILE_W,
  parameter int TILE_H       = DEF_TILE_H,
  parameter int ASCII_LEVELS = DEF_ASCII_LEVELS,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic                                                      clk,
  input  logic                                                      rst,
  input  logic                                                      start,
  output logic                                                      busy,
  output logic                                                      done,
  output logic [$clog2(FRAME_W/TILE_W)-1:0]                         tile_x,
  output logic [$clog2(FRAME_H/TILE_H)-1:0]                         tile_y,
  output logic                                                      load_req,
  input  logic                                                      load_ack,
  output logic                                                      fill_enable,
  input  logic                                                      fill_ready,
  input  logic [$clog2(ASCII_LEVELS)-1:0]                           fill_ascii,
  output logic                                                      char_wr_en,
  output logic [$clog2((FRAME_W/TILE_W)*(FRAME_H/TILE_H))-1:0]      char_wr_addr,
  output logic [$clog2(ASCII_LEVELS)-1:0]                           char_wr_data,
  input  logic                                                      char_wr_ready,
  output logic                                                      timeout_err
);

  localparam int COLS   = FRAME_W / TILE_W;
  localparam int ROWS   = FRAME_H / TILE_H;
  localparam int XW     = $clog2(COLS);
  localparam int YW     = $clog2(ROWS);
  localparam int ADDR_W = $clog2(COLS * ROWS);
  localparam int LVL_W  = $clog2(ASCII_LEVELS);

  if (FRAME_W % TILE_W != 0) begin : g_bad_w
    $error("FRAME_W must be a multiple of TILE_W");
  end
  if (FRAME_H % TILE_H != 0) begin : g_bad_h
    $error("FRAME_H must be a multiple of TILE_H");
  end
  if (TIMEOUT < 1) begin : g_bad_to
    $error("TIMEOUT must be at least 1");
  end

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [LVL_W-1:0] data_q;
  logic             last_tile;
  logic             wr_accept;

  assign wr_accept = (state == WRITE) && char_wr_ready;

  ascii_tile_cursor #(
    .COLS (COLS),
    .ROWS (ROWS),
    .XW   (XW),
    .YW   (YW)
  ) u_cursor (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == DONE),
    .advance (wr_accept && !last_tile),
    .tile_x  (tile_x),
    .tile_y  (tile_y),
    .last    (last_tile)
  );

`ifdef ASCII_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;
  logic          to_err_q;
  logic          to_hit;

  // Loaded while in FILL so terminal count lands on the TIMEOUT-th WAIT cycle.
  assign to_hit = (state == WAIT) && !fill_ready && (to_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt   <= '0;
      to_err_q <= 1'b0;
    end else begin
      if (state == FILL)
        to_cnt <= TW'(TIMEOUT - 1);
      else if (state == WAIT && to_cnt != '0)
        to_cnt <= to_cnt - TW'(1);
      if (to_hit)
        to_err_q <= 1'b1;
    end
  end

  assign timeout_err = to_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = LOAD;
      LOAD:  if (load_ack) state_nxt = FILL;
      FILL:  state_nxt = WAIT;
      WAIT: begin
        if (fill_ready) state_nxt = WRITE;
`ifdef ASCII_SEQ_TIMEOUT_EN
        else if (to_hit) state_nxt = WRITE;
`endif
      end
      WRITE: if (char_wr_ready) state_nxt = last_tile ? DONE : LOAD;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      data_q <= '0;
    else if (state == WAIT && fill_ready)
      data_q <= fill_ascii;
`ifdef ASCII_SEQ_TIMEOUT_EN
    else if (to_hit)
      data_q <= '0;
`endif
  end

  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign load_req     = (state == LOAD);
  assign fill_enable  = (state == FILL);
  assign char_wr_en   = (state == WRITE);
  assign char_wr_data = data_q;
  assign char_wr_addr = ADDR_W'(tile_addr(int'(tile_x), int'(tile_y), COLS));

endmodule

// File: tb/tb_ascii_tile_sequencer.sv
// Scoreboard bench for ascii_tile_sequencer on a 32x16 frame of 8x8 tiles (4x2 tiles).
// Build with ASCII_SEQ_TIMEOUT_EN to also exercise the fill watchdog.
module tb_ascii_tile_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, load_req, fill_enable, char_wr_en, timeout_err;
  logic [1:0] tile_x;
  logic [0:0] tile_y;
  logic       load_ack = 1'b0;
  logic       fill_ready = 1'b0;
  logic [2:0] fill_ascii = 3'd0;
  logic [2:0] char_wr_addr;
  logic [2:0] char_wr_data;
  logic       char_wr_ready = 1'b0;

  ascii_tile_sequencer #(
    .FRAME_W(32), .FRAME_H(16), .TILE_W(8), .TILE_H(8), .ASCII_LEVELS(8), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .tile_x(tile_x), .tile_y(tile_y), .load_req(load_req), .load_ack(load_ack),
    .fill_enable(fill_enable), .fill_ready(fill_ready), .fill_ascii(fill_ascii),
    .char_wr_en(char_wr_en), .char_wr_addr(char_wr_addr), .char_wr_data(char_wr_data),
    .char_wr_ready(char_wr_ready), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;

  // stimulus knobs
  int ack_tile = -1;
  int stall_tile = -1;
  int never_tile = -1;
  bit spur = 1'b0;

  // responder state
  int fill_cnt = 0;
  int load_cyc = 0;
  int wr_cyc = 0;
  bit fill_pend = 1'b0;

  // monitor records
  int load_len[8];
  int wr_len[8];
  int exp_addr_q[$];
  int exp_data_q[$];
  int done_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Loader / fill / char-buffer responder
  initial forever begin
    @(negedge clk);
    if (rst || done) begin
      fill_cnt = 0; load_cyc = 0; wr_cyc = 0; fill_pend = 1'b0;
      load_ack = 1'b0; fill_ready = 1'b0; fill_ascii = 3'd0; char_wr_ready = 1'b0;
    end else begin
      if (load_req) begin
        load_cyc++;
        load_ack = (load_cyc > ((fill_cnt == ack_tile) ? 5 : 0));
      end else begin
        load_cyc = 0;
        load_ack = 1'b0;
      end
      fill_ready = 1'b0;
      fill_ascii = 3'd0;
      if (fill_pend && (fill_cnt - 1) != never_tile) begin
        fill_ready = 1'b1;
        fill_ascii = 3'((fill_cnt - 1) % 4 + (fill_cnt - 1) / 4);
      end
      fill_pend = fill_enable;
      if (fill_enable) begin
        fill_cnt++;
        if (spur) begin
          fill_ready = 1'b1;
          fill_ascii = 3'd7;
        end
      end
      if (char_wr_en) begin
        wr_cyc++;
        char_wr_ready = (wr_cyc > (((fill_cnt - 1) == stall_tile) ? 3 : 0));
      end else begin
        wr_cyc = 0;
        char_wr_ready = 1'b0;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    bit prev_la = 1'b0, prev_wr = 1'b0, prev_done = 1'b0;
    int prev_data = 0;
    int load_run = 0, load_k = 0, wr_run = 0, wr_k = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        chk("one_hot_ctrl", int'($countones({load_req, fill_enable, char_wr_en, done}) <= 1), 1);
        if (load_req) begin
          chk("load_tile_x", int'(tile_x), fill_cnt % 4);
          chk("load_tile_y", int'(tile_y), fill_cnt / 4);
          load_run++;
          load_k = fill_cnt;
        end else if (load_run > 0) begin
          load_len[load_k & 7] = load_run;
          load_run = 0;
        end
        if (fill_enable) begin
          chk("fill_after_ack", int'(prev_la), 1);
          chk("fill_tile_x", int'(tile_x), (fill_cnt - 1) % 4);
        end
        if (char_wr_en) begin
          chk("wr_addr_hold", int'(char_wr_addr), fill_cnt - 1);
          if (prev_wr) chk("wr_data_hold", int'(char_wr_data), prev_data);
          wr_run++;
          wr_k = fill_cnt - 1;
        end else if (wr_run > 0) begin
          wr_len[wr_k & 7] = wr_run;
          wr_run = 0;
        end
        if (load_req || fill_enable || char_wr_en || done) chk("busy", int'(busy), 1);
        if (char_wr_en && char_wr_ready) begin
          chk("wr_expected", int'(exp_addr_q.size() > 0), 1);
          if (exp_addr_q.size() > 0) begin
            chk("wr_addr", int'(char_wr_addr), exp_addr_q.pop_front());
            chk("wr_data", int'(char_wr_data), exp_data_q.pop_front());
          end
        end
        if (done) begin
          chk("done_single", int'(prev_done), 0);
          chk("done_expected", int'(done_q.size() > 0), 1);
          if (done_q.size() > 0) chk("done_cycle", cyc, done_q.pop_front());
          done_cnt++;
        end
        chk("busy_idle", int'(busy), int'(load_req || fill_enable || char_wr_en || done || busy));
      end
      prev_la   = load_req && load_ack;
      prev_wr   = char_wr_en;
      prev_data = int'(char_wr_data);
      prev_done = done;
    end
  end

  function automatic int outs_vec();
    return int'({busy, done, tile_x, tile_y, load_req, fill_enable, char_wr_en,
                 char_wr_addr, char_wr_data, timeout_err});
  endfunction

  task automatic push_frame(input int to_tile);
    for (int k = 0; k < 8; k++) begin
      exp_addr_q.push_back(k);
      exp_data_q.push_back((k == to_tile) ? 0 : (k % 4 + k / 4));
    end
  endtask

  task automatic run_frame(input int dly, input int hold);
    int d0, n;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    done_q.push_back(start_cyc + dly);
    @(posedge clk);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done_cnt, d0 + 1);
    repeat (3) @(negedge clk);
    chk("busy_after_done", int'(busy), 0);
    chk("wr_q_drained", exp_addr_q.size(), 0);
    chk("tile_cleared", int'({tile_x, tile_y}), 0);
  endtask

  initial begin
    int n, d0;
    repeat (3) @(negedge clk);
    #1 chk("reset_outputs", outs_vec(), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    // 1: immediate handshakes
    push_frame(-1);
    run_frame(33, 0);

    // 2: delayed load_ack on tile 2
    ack_tile = 2;
    push_frame(-1);
    run_frame(38, 0);
    chk("load_len_t2", load_len[2], 6);
    chk("load_len_t1", load_len[1], 1);
    ack_tile = -1;

    // 3: char buffer stall on tile 3
    stall_tile = 3;
    push_frame(-1);
    run_frame(36, 0);
    chk("wr_len_t3", wr_len[3], 4);
    chk("wr_len_t2", wr_len[2], 1);
    stall_tile = -1;

    // 4: reset while waiting on tile 5
    never_tile = 5;
    push_frame(-1);
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (fill_cnt < 6 && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("reached_tile5", fill_cnt, 6);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1 chk("abort_outputs", outs_vec(), 0);
    rst = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    never_tile = -1;
    repeat (5) @(negedge clk);
    chk("abort_no_done", done_cnt, d0);
    push_frame(-1);
    run_frame(33, 0);

    // 5: start re-pulsed while busy plus stale fill_ready during FILL
    spur = 1'b1;
    push_frame(-1);
    run_frame(33, 20);
    spur = 1'b0;

`ifdef ASCII_SEQ_TIMEOUT_EN
    // 6: fill never answers on tile 1
    chk("timeout_err_clear", int'(timeout_err), 0);
    never_tile = 1;
    push_frame(1);
    run_frame(48, 0);
    chk("timeout_err_set", int'(timeout_err), 1);
    never_tile = -1;
    push_frame(-1);
    run_frame(33, 0);
    chk("timeout_err_sticky", int'(timeout_err), 1);
`else
    chk("timeout_err_tied", int'(timeout_err), 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish by %0t", $time);
    $fatal(1);
  end

endmodule
